// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared constants, reference coefficients and coefficient conversion for the fir filter
package fir_pkg;

  localparam int NUM_TAPS      = 15;
  localparam int COEF_REF_FRAC = 8;
  localparam int ACC_GUARD     = 4;

  // Symmetric low-pass taps scaled by 2^COEF_REF_FRAC; they sum to 256 (unity DC gain).
  localparam int H [0:NUM_TAPS-1] = '{-1, -3, -4, 2, 16, 35, 53, 60, 53, 35, 16, 2, -4, -3, -1};

  function automatic int coef_conv(input int h, input int frac_wl, input int inte_wl);
    int v;
    int hi;
    int lo;
    if (frac_wl >= COEF_REF_FRAC)
      v = h <<< (frac_wl - COEF_REF_FRAC);
    else
      v = h >>> (COEF_REF_FRAC - frac_wl);
    hi = (1 <<< (inte_wl + frac_wl - 1)) - 1;
    lo = -hi - 1;
    if (v > hi)
      v = hi;
    else if (v < lo)
      v = lo;
    return v;
  endfunction

endpackage

// File: rtl/fir_tap.sv
// rtl/fir_tap.sv - one tap: exact product, floor to the tap's fractional width, realign to accumulator format
module fir_tap
  import fir_pkg::*;
#(
  parameter int COE_W = 12,
  parameter int IN_W  = 12,
  parameter int COEF  = 0,
  parameter int DROP  = 4,
  parameter int ACC_W = 28
) (
  input  logic signed [IN_W-1:0]  x,
  output logic signed [ACC_W-1:0] term
);

  localparam int PROD_W = COE_W + IN_W;
  localparam logic signed [COE_W-1:0] C = COE_W'(COEF);
  localparam logic [PROD_W-1:0] KEEP = {PROD_W{1'b1}} << DROP;

  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] trunc;

  assign prod  = C * x;
  // Clearing the dropped LSBs of a two's-complement value is a floor that is already realigned.
  assign trunc = prod & KEEP;
  assign term  = ACC_W'(trunc);

endmodule

// File: rtl/fir.sv
// rtl/fir.sv - 15-tap direct-form FIR with per-tap product truncation and saturating output
module fir
  import fir_pkg::*;
#(
  parameter int COE_INTE_WL = 4,
  parameter int COE_FRAC_WL = 8,
  parameter int IN_INTE_WL  = 4,
  parameter int IN_FRAC_WL  = 8,
  parameter int OUT_INTE_WL = 4,
  parameter int OUT_FRAC_WL = 8,
  parameter int PRODUCT_FRAC_WL_ARRAY [0:14] = '{12, 12, 12, 12, 12, 12, 12, 12, 12, 12, 12, 12, 12, 12, 12}
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic signed [IN_INTE_WL-1:-IN_FRAC_WL]        data_in,
  input  logic                                          in_valid,
  output logic signed [OUT_INTE_WL-1:-OUT_FRAC_WL]      data_out,
  output logic                                          out_valid
);

  localparam int COE_W    = COE_INTE_WL + COE_FRAC_WL;
  localparam int IN_W     = IN_INTE_WL + IN_FRAC_WL;
  localparam int OUT_W    = OUT_INTE_WL + OUT_FRAC_WL;
  localparam int ACC_FRAC = COE_FRAC_WL + IN_FRAC_WL;
  localparam int ACC_W    = COE_INTE_WL + IN_INTE_WL + ACC_GUARD + ACC_FRAC;
  localparam int UP       = (OUT_FRAC_WL > ACC_FRAC) ? OUT_FRAC_WL - ACC_FRAC : 0;
  localparam int DN       = (ACC_FRAC > OUT_FRAC_WL) ? ACC_FRAC - OUT_FRAC_WL : 0;
  localparam int SC_W     = ACC_W + UP;
  localparam logic signed [SC_W-1:0] SAT_MAX = SC_W'((1 <<< (OUT_W - 1)) - 1);
  localparam logic signed [SC_W-1:0] SAT_MIN = SC_W'(-(1 <<< (OUT_W - 1)));

  logic signed [IN_W-1:0]  x     [0:NUM_TAPS-1];
  logic signed [ACC_W-1:0] terms [0:NUM_TAPS-1];
  logic signed [ACC_W-1:0] acc;
  logic signed [SC_W-1:0]  scaled;
  logic signed [SC_W-1:0]  sat;
  logic                    valid_d1;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_TAPS; k++) x[k] <= '0;
    end else if (in_valid) begin
      x[0] <= data_in;
      for (int k = 1; k < NUM_TAPS; k++) x[k] <= x[k-1];
    end
  end

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
    fir_tap #(
      .COE_W (COE_W),
      .IN_W  (IN_W),
      .COEF  (coef_conv(H[k], COE_FRAC_WL, COE_INTE_WL)),
      .DROP  (ACC_FRAC - PRODUCT_FRAC_WL_ARRAY[k]),
      .ACC_W (ACC_W)
    ) u_tap (
      .x    (x[k]),
      .term (terms[k])
    );
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k < NUM_TAPS; k++) acc = acc + terms[k];
  end

  // Arithmetic shift right floors toward -inf, matching the output rounding rule.
  always_comb begin
    scaled = (SC_W'(acc) <<< UP) >>> DN;
    sat    = scaled;
    if (scaled > SAT_MAX)
      sat = SAT_MAX;
    else if (scaled < SAT_MIN)
      sat = SAT_MIN;
  end

  // data_out only moves when the previous edge accepted a sample, so it holds across gaps.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_d1  <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
    end else begin
      valid_d1  <= in_valid;
      out_valid <= valid_d1;
      if (valid_d1) data_out <= sat[OUT_W-1:0];
    end
  end

endmodule

// File: tb/tb_fir.sv
// tb/tb_fir.sv - randomized and directed self-checking bench for fir against a sample-level reference model
module tb_fir;

  logic               clk;
  logic               rst;
  logic signed [11:0] data_in;
  logic               in_valid;
  logic signed [11:0] data_out;
  logic               out_valid;

  int n_cmp;
  int n_bad;

  fir dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .data_out  (data_out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int coefs [0:14] = '{-1, -3, -4, 2, 16, 35, 53, 60, 53, 35, 16, 2, -4, -3, -1};
  int imp_exp  [0:15] = '{-1, -3, -4, 2, 16, 35, 53, 60, 53, 35, 16, 2, -4, -3, -1, 0};
  int step_exp [0:14] = '{-1, -4, -8, -6, 10, 45, 98, 158, 211, 246, 262, 264, 260, 257, 256};
  int trunc_exp[0:15] = '{-1, -1, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, -1, -1, 0};

  int  hist[$];
  int  got[$];
  bit  pend;
  int  pend_y;
  bit  exp_valid;
  int  exp_out;

  function automatic int floor_div(input int a, input int d);
    int q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Each product h*x has 16 fractional bits; keeping 12 is floor(p/16)*16, output keeps 8 bits.
  function automatic int model_y();
    int acc;
    int y;
    acc = 0;
    for (int k = 0; k < hist.size(); k++)
      acc += floor_div(coefs[k] * hist[k], 16) * 16;
    y = floor_div(acc, 256);
    if (y > 2047) y = 2047;
    if (y < -2048) y = -2048;
    return y;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit v, input int d);
    logic [31:0] dv;
    dv       = d;
    rst      = r;
    in_valid = v;
    data_in  = dv[11:0];
    @(posedge clk);
    if (r) begin
      hist.delete();
      pend      = 1'b0;
      exp_valid = 1'b0;
      exp_out   = 0;
    end else begin
      exp_valid = pend;
      if (pend) exp_out = pend_y;
      if (v) begin
        hist.push_front(d);
        if (hist.size() > 15) void'(hist.pop_back());
        pend_y = model_y();
      end
      pend = v;
    end
    @(negedge clk);
    check("out_valid", int'(out_valid), int'(exp_valid));
    check("data_out", int'(data_out), exp_out);
    if (out_valid) got.push_back(int'(data_out));
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1000);
    step(1'b1, 1'b0, 0);
    got.delete();
  endtask

  task automatic check_got(input string name, input int idx, input int exp);
    if (idx < got.size())
      check(name, got[idx], exp);
    else begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: output %0d missing, got %0d outputs expected %0d", name, idx, got.size(), idx + 1);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    pend  = 1'b0;

    do_reset();
    check("reset_data_out", int'(data_out), 0);
    check("reset_out_valid", int'(out_valid), 0);

    // Impulse of 1.0: first value two edges after acceptance.
    step(1'b0, 1'b1, 256);
    check("impulse_latency_n", int'(out_valid), 0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 0);
    for (int i = 0; i < 16; i++) check_got("impulse", i, imp_exp[i]);

    do_reset();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 256);
    for (int i = 0; i < 15; i++) check_got("step", i, step_exp[i]);
    for (int i = 15; i < 19; i++) check_got("step_settle", i, 256);

    do_reset();
    for (int i = 0; i < 40; i++) step(1'b0, (i % 2) == 0, ((i % 2) == 0) ? 256 : $urandom_range(0, 4095) - 2048);
    for (int i = 0; i < 15; i++) check_got("gap_step", i, step_exp[i]);

    do_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 256);
    step(1'b1, 1'b1, 256);
    check("midreset_data_out", int'(data_out), 0);
    check("midreset_out_valid", int'(out_valid), 0);
    got.delete();
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 256);
    for (int i = 0; i < 15; i++) check_got("restart_step", i, step_exp[i]);

    do_reset();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 2047);
    for (int i = 10; i < 14; i++) check_got("sat_pos", i, 2047);

    do_reset();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, -2048);
    for (int i = 10; i < 19; i++) check_got("sat_neg", i, -2048);

    do_reset();
    step(1'b0, 1'b1, 1);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 0);
    for (int i = 0; i < 16; i++) check_got("trunc", i, trunc_exp[i]);

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0)
        step(1'b1, $urandom_range(0, 1) == 1, 0);
      else
        step(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 4095) - 2048);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
